// File: rtl/data_link_pkg.sv
// data_link_pkg: definitions shared by the serial link endpoints.
//   - line levels for idle, start and stop bits
//   - default bit period in clocks
//   - receiver FSM state encoding
//   - 2-of-3 majority helper used when DATA_RECV_MAJORITY_EN is defined
package data_link_pkg;

    localparam logic LINE_IDLE  = 1'b0;
    localparam logic LINE_START = 1'b1;
    localparam logic LINE_STOP  = 1'b0;

    localparam int DEFAULT_BIT_CYCLES = 50;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/data_recv_rx_sync.sv
// rx_sync: brings the asynchronous serial line into the clk domain.
// Ports:
//   clk   in   system clock
//   rst_n in   synchronous active-low reset
//   rx    in   raw serial line
//   rx_s  out  line after a 2-flop synchronizer
//   rise  out  0->1 transition of rx_s (rx_s high, one-cycle-older copy low)
module rx_sync
    import data_link_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= LINE_IDLE;
            sync_q <= LINE_IDLE;
            dly_q  <= LINE_IDLE;
        end else begin
            meta_q <= rx;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign rx_s = sync_q;
    assign rise = sync_q & ~dly_q;

endmodule

// File: rtl/data_recv.sv
// data_recv: serial frame receiver (idle 0, start 1, 8 data bits LSB first,
// stop 0, BIT_CYCLES clocks per bit). Each bit is sampled at its centre,
// timed from the centre of the start bit.
// Ports:
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset
//   en        in   receiver enable, 0 forces IDLE and drops any partial frame
//   rx        in   serial line, asynchronous to clk
//   data      out  last correctly received byte
//   rx_done   out  one-cycle pulse, data updated this cycle
//   frame_err out  one-cycle pulse, stop bit sampled as 1
//   busy      out  high while a frame is in progress
// Build option: define DATA_RECV_MAJORITY_EN to take every sample as the
// 2-of-3 majority of centre-1/centre/centre+1, decided one clock later.
module data_recv
    import data_link_pkg::*;
#(
    parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int HALF  = BIT_CYCLES / 2;
    localparam int CNT_W = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);
`ifdef DATA_RECV_MAJORITY_EN
    // Decision lands one clock after the centre; later samples inherit the shift.
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF);
`else
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF - 1);
`endif

    logic rx_s;
    logic rise;
    logic sample_bit;
    logic start_ok;

    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shreg_q;
    logic [7:0]       data_q;
    logic             rx_done_q;
    logic             frame_err_q;
    logic             busy_q;
    logic [1:0]       warm_q;

    rx_sync u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .rx_s  (rx_s),
        .rise  (rise)
    );

`ifdef DATA_RECV_MAJORITY_EN
    logic hist1_q;
    logic hist2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist1_q <= LINE_IDLE;
            hist2_q <= LINE_IDLE;
        end else begin
            hist1_q <= rx_s;
            hist2_q <= hist1_q;
        end
    end

    assign sample_bit = maj3(rx_s, hist1_q, hist2_q);
`else
    assign sample_bit = rx_s;
`endif

    // The synchronizer restarts from 0 after reset, so a line that is already
    // high would look like a fresh 0->1 edge. Ignore edges until the delay
    // flop holds a real observation of the line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            warm_q <= 2'd0;
        end else if (warm_q != 2'd3) begin
            warm_q <= warm_q + 2'd1;
        end
    end

    assign start_ok = rise & (warm_q == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            if (!en) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                bit_idx_q <= '0;
                shreg_q   <= '0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        if (start_ok) begin
                            state_q <= START;
                            busy_q  <= 1'b1;
                        end
                    end
                    START: begin
                        if (cnt_q == START_LAST) begin
                            cnt_q     <= '0;
                            bit_idx_q <= '0;
                            if (sample_bit == LINE_START) begin
                                state_q <= DATA;
                            end else begin
                                // Too short to be a start bit: drop silently.
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cnt_q == BIT_LAST) begin
                            cnt_q              <= '0;
                            shreg_q[bit_idx_q] <= sample_bit;
                            if (bit_idx_q == 3'd7) begin
                                state_q <= STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    STOP: begin
                        if (cnt_q == BIT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            if (sample_bit == LINE_STOP) begin
                                data_q    <= shreg_q;
                                rx_done_q <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data      = data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule
